// File: rtl/encoder_controller.sv
// Round sequencer for the encoder datapath: pulses each stage in turn, waits for its
// ready, steps the round counter, and traps stalled stages or round-count disagreements.
module encoder_controller #(
    parameter int TIMEOUT = 255,
    parameter int ROUNDS  = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ready_par,
    input  logic       ready_rot,
    input  logic       ready_per,
    input  logic       ready_rev,
    input  logic       ready_RC,
    input  logic       co,
    output logic       start_par,
    output logic       start_rot,
    output logic       start_per,
    output logic       start_rev,
    output logic       start_RC,
    output logic       cnt_up,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] round_idx
);

    typedef enum logic [3:0] {
        IDLE, PAR_S, PAR_W, ROT_S, ROT_W, PER_S, PER_W,
        REV_S, REV_W, RC_S, RC_W, INC, DONE, ERR
    } state_t;

    localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);
    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    state_t     state, state_next;
    logic [9:0] wdog;
    logic       last_round;
    logic       wd_expired;
    logic       co_ok;

    assign wd_expired = (wdog == WD_LAST);
    // co must be high exactly on the final round, otherwise the datapath counter is out of step
    assign co_ok      = (co == (round_idx == LAST_IDX));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PAR_S;
            PAR_S:   state_next = PAR_W;
            PAR_W:   if (ready_par) state_next = ROT_S;
                     else if (wd_expired) state_next = ERR;
            ROT_S:   state_next = ROT_W;
            ROT_W:   if (ready_rot) state_next = PER_S;
                     else if (wd_expired) state_next = ERR;
            PER_S:   state_next = PER_W;
            PER_W:   if (ready_per) state_next = REV_S;
                     else if (wd_expired) state_next = ERR;
            REV_S:   state_next = REV_W;
            REV_W:   if (ready_rev) state_next = RC_S;
                     else if (wd_expired) state_next = ERR;
            RC_S:    state_next = RC_W;
            RC_W:    if (ready_RC) state_next = co_ok ? INC : ERR;
                     else if (wd_expired) state_next = ERR;
            INC:     state_next = last_round ? DONE : PAR_S;
            DONE:    state_next = IDLE;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wdog       <= '0;
            last_round <= 1'b0;
            round_idx  <= '0;
            start_par  <= 1'b0;
            start_rot  <= 1'b0;
            start_per  <= 1'b0;
            start_rev  <= 1'b0;
            start_RC   <= 1'b0;
            cnt_up     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;

            // Watchdog counts wait cycles only; any non-wait state (including X_S) clears it
            case (state)
                PAR_W, ROT_W, PER_W, REV_W, RC_W: wdog <= wdog + 10'd1;
                default:                          wdog <= '0;
            endcase

            if (state == RC_W && ready_RC)
                last_round <= co;

            if (state == IDLE && start)
                round_idx <= '0;
            else if (state == INC && !last_round)
                round_idx <= round_idx + 5'd1;

            // Outputs decoded from the next state so they line up with the state register
            start_par <= (state_next == PAR_S);
            start_rot <= (state_next == ROT_S);
            start_per <= (state_next == PER_S);
            start_rev <= (state_next == REV_S);
            start_RC  <= (state_next == RC_S);
            cnt_up    <= (state_next == INC);
            done      <= (state_next == DONE);
            err       <= (state_next == ERR);
            busy      <= !(state_next inside {IDLE, DONE, ERR});
        end
    end

endmodule

// File: doc/encoder_controller.md
Name: encoder_controller

Overview:
- Control FSM sitting directly upstream of the encoder datapath.
- Sequences one message through 24 rounds of column-parity, rotate, permute, revaluate and add-round-constant.
- Issues one-cycle start pulses to each stage, waits for that stage's ready, and steps the datapath's 24-round counter via cnt_up.
- Detects the final round from the counter's co, signals completion to the top level, and flags a stalled stage through a watchdog.

Parameters:
- TIMEOUT, 255: maximum cycles spent in any single WAIT state before entering ERR; legal range 1..1023.
- ROUNDS, 24: expected round count; used only for round_idx range and checking, must match the datapath counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin processing one message; sampled only in IDLE
- ready_par  in  1  column-parity stage finished
- ready_rot  in  1  rotate stage finished
- ready_per  in  1  permute stage finished
- ready_rev  in  1  revaluate stage finished
- ready_RC  in  1  add-round-constant stage finished
- co  in  1  datapath round counter is at its final value (round 23)
- start_par  out  1  one-cycle start pulse to column-parity stage
- start_rot  out  1  one-cycle start pulse to rotate stage
- start_per  out  1  one-cycle start pulse to permute stage
- start_rev  out  1  one-cycle start pulse to revaluate stage
- start_RC  out  1  one-cycle start pulse to add-round-constant stage
- cnt_up  out  1  one-cycle increment pulse to the round counter
- busy  out  1  high from the cycle after start is accepted until DONE or ERR
- done  out  1  one-cycle pulse when all rounds have completed
- err  out  1  sticky watchdog error flag
- round_idx  out  5  current round, 0..ROUNDS-1

Behaviour:
- Reset: rst=0 asynchronously forces IDLE and clears every output to 0, including round_idx and the watchdog count. Reset mid-run abandons the run; no done is issued.
- States: IDLE, PAR_S, PAR_W, ROT_S, ROT_W, PER_S, PER_W, REV_S, REV_W, RC_S, RC_W, INC, DONE, ERR. All outputs are registered (Moore).
- IDLE: on start=1, clear round_idx and go to PAR_S; start is ignored in every other state.
- Each X_S state drives its start_X=1 for exactly one cycle, clears the watchdog, then moves to X_W.
- X_W: stays until the matching ready_X=1 is sampled.
  - Stage order: PAR, ROT, PER, REV, RC.
  - From the RC_W exit, go to INC.
  - Ready lines of other stages are ignored in any state.
  - A ready already high in the X_S cycle is not sampled. The earliest accepted ready is the cycle after the start pulse.
- RC_W: when ready_RC=1 is sampled, latch co into last_round.
- INC:
  - Drive cnt_up=1 for one cycle. The counter is always stepped, so it wraps from 23 back to 0 after the final round.
  - If last_round=1, go to DONE.
  - Otherwise increment round_idx and go to PAR_S.
- DONE: done=1 and busy=0 for one cycle, then IDLE. round_idx holds 23 until the next accepted start.
- Watchdog:
  - Counts cycles in each W state.
  - When the count reaches TIMEOUT with ready still low, go to ERR. The transition is taken on the TIMEOUT-th wait cycle, so ERR is entered TIMEOUT+1 cycles after the start pulse.
  - ERR: err=1, busy=0, no start or cnt_up pulses. Only rst leaves ERR.
- Round consistency check: if co is sampled 0 in RC_W while round_idx=ROUNDS-1, or 1 while round_idx<ROUNDS-1, go to ERR.
- Timing with single-cycle stages (ready one cycle after start):
  - Each round takes 11 cycles.
  - start sampled in IDLE at cycle 0; start_par pulses at cycle 1.
  - Final INC at cycle 264; done at cycle 265.

Test Plan:
- Reset: rst=0 mid-run in ROT_W -> all outputs 0 immediately. After release, IDLE; no done.
- Nominal run, stage models with 1-cycle ready and a counter24 model -> 24 start_par pulses, 24 cnt_up pulses, done at cycle 265, round_idx 0..23, counter back at 0.
- Variable latency: ready_per delayed 7 cycles in round 5; ready_rot asserted high during ROT_S -> exactly one start_rot pulse per round, FSM waits correctly, done delayed by exactly 6 cycles.
- Spurious inputs: ready_RC pulsed during PAR_W; start pulsed while busy -> ignored, no extra pulses, single done.
- Watchdog: TIMEOUT=8, ready_rev held low -> ERR entered 9 cycles after start_rev, err=1, busy=0, then silent until rst.
- Round mismatch: co forced 1 at round_idx=3 -> ERR, no done.
